// File: rtl/mips_pkg.sv
// mips_pkg: shared word type, fetch FSM state encodings and default
// address constants for the MIPS front end.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam word_t DEFAULT_EXC_VECTOR = 32'h0000_0020;

    // Fetch sequencer states, kept as plain constants so older tools that
    // only understand vectors can still read the netlist.
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/pc_next_select.sv
// pc_next_select: combinational next-PC selection for the fetch unit.
// Priority is exception > jump > branch > pending redirect > PC+1.
// It also reports whether a fresh redirect arrived this cycle and its target.
module pc_next_select
    import mips_pkg::*;
#(
    parameter word_t EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic  i_exc,
    input  logic  i_jmp,
    input  word_t i_jmp_target,
    input  logic  i_br_taken,
    input  word_t i_br_target,
    input  logic  i_redir_pend,
    input  word_t i_pend_target,
    input  word_t i_pc,
    output logic  o_redirect,
    output word_t o_redirect_target,
    output word_t o_pc_plus1,
    output word_t o_pc_next
);

    word_t w_pc_plus1;

    assign w_pc_plus1 = i_pc + 32'd1;
    assign o_pc_plus1 = w_pc_plus1;

    // Pick the highest-priority redirect, falling back to a pending one and then sequential fetch.
    always_comb begin
        o_redirect        = 1'b0;
        o_redirect_target = w_pc_plus1;
        o_pc_next         = w_pc_plus1;
        if (i_exc) begin
            o_redirect        = 1'b1;
            o_redirect_target = EXC_VECTOR;
        end else if (i_jmp) begin
            o_redirect        = 1'b1;
            o_redirect_target = i_jmp_target;
        end else if (i_br_taken) begin
            o_redirect        = 1'b1;
            o_redirect_target = i_br_target;
        end
        if (o_redirect) begin
            o_pc_next = o_redirect_target;
        end else if (i_redir_pend) begin
            o_pc_next = i_pend_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch sequencer.
// Issues one outstanding instruction-memory request at a time, delivers
// fetched words to IF/ID through an output register, and parks one extra
// word when the output register is stalled so a completed request is never lost.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter word_t RESET_PC   = DEFAULT_RESET_PC,
    parameter word_t EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        exc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus1_o
);

    logic [1:0] r_state;
    word_t      r_pc;
    logic       r_redir_pend;
    word_t      r_redir_target;

    logic       r_valid;
    word_t      r_instr;
    word_t      r_if_pc;
    word_t      r_if_pc_plus1;

    word_t      r_park_instr;
    word_t      r_park_pc;
    word_t      r_park_plus1;

    logic       w_redirect;
    word_t      w_redirect_target;
    word_t      w_pc_plus1;
    word_t      w_pc_next;
    logic       w_consume;
    logic       w_free;
    logic       w_ack_req;
    logic       w_accept;
    logic       w_capture;
    logic       w_park;
    logic       w_unpark;

    pc_next_select #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next (
        .i_exc             (exc_i),
        .i_jmp             (jmp_i),
        .i_jmp_target      (jmp_target_i),
        .i_br_taken        (br_taken_i),
        .i_br_target       (br_target_i),
        .i_redir_pend      (r_redir_pend),
        .i_pend_target     (r_redir_target),
        .i_pc              (r_pc),
        .o_redirect        (w_redirect),
        .o_redirect_target (w_redirect_target),
        .o_pc_plus1        (w_pc_plus1),
        .o_pc_next         (w_pc_next)
    );

    // A completed request delivers a real instruction only when no redirect
    // (new or pending) has made it wrong-path; it then either lands in the
    // output register (if that frees up this cycle) or parks until it does.
    assign w_consume = r_valid & ~stall_i;
    assign w_free    = ~r_valid | ~stall_i;
    assign w_ack_req = (r_state == ST_REQ) & imem_ack_i;
    assign w_accept  = w_ack_req & ~w_redirect & ~r_redir_pend;
    assign w_capture = w_accept & w_free;
    assign w_park    = w_accept & ~w_free;
    assign w_unpark  = (r_state == ST_HOLD) & w_consume & ~w_redirect;

    assign imem_req_o    = (r_state == ST_REQ);
    assign imem_addr_o   = r_pc;
    assign if_valid_o    = r_valid;
    assign if_instr_o    = r_instr;
    assign if_pc_o       = r_if_pc;
    assign if_pc_plus1_o = r_if_pc_plus1;

    // Fetch FSM, program counter and deferred-redirect bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_BOOT;
            r_pc           <= RESET_PC;
            r_redir_pend   <= 1'b0;
            r_redir_target <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_REQ;
                    if (w_redirect) begin
                        r_pc <= w_pc_next;
                    end
                end
                ST_REQ: begin
                    if (imem_ack_i) begin
                        r_pc         <= w_pc_next;
                        r_redir_pend <= 1'b0;
                        if (w_park) begin
                            r_state <= ST_HOLD;
                        end
                    end else if (w_redirect) begin
                        r_redir_pend   <= 1'b1;
                        r_redir_target <= w_redirect_target;
                    end
                end
                ST_HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_pc_next;
                        r_state <= ST_REQ;
                    end else if (w_consume) begin
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    // IF/ID output register: redirects flush it, fresh or parked words refill it, consumption empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_instr       <= '0;
            r_if_pc       <= '0;
            r_if_pc_plus1 <= '0;
        end else begin
            if (w_redirect) begin
                r_valid <= 1'b0;
            end else if (w_capture || w_unpark) begin
                r_valid <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
            if (w_capture) begin
                r_instr       <= imem_rdata_i;
                r_if_pc       <= r_pc;
                r_if_pc_plus1 <= w_pc_plus1;
            end else if (w_unpark) begin
                r_instr       <= r_park_instr;
                r_if_pc       <= r_park_pc;
                r_if_pc_plus1 <= r_park_plus1;
            end
        end
    end

    // Parking slot for a word that returned while the output register was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_park_instr <= '0;
            r_park_pc    <= '0;
            r_park_plus1 <= '0;
        end else if (w_park) begin
            r_park_instr <= imem_rdata_i;
            r_park_pc    <= r_pc;
            r_park_plus1 <= w_pc_plus1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for the fetch unit with a scoreboard of
// expected IF/ID words, plus a second instance booting at the top of memory.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        jmp_i;
    logic [31:0] jmp_target_i;
    logic        exc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus1_o;

    logic        wAck;
    logic [31:0] wRdata;
    logic        wZero;
    logic [31:0] wZeroWord;
    logic        wReq;
    logic [31:0] wAddr;
    logic        wValid;
    logic [31:0] wInstr;
    logic [31:0] wPc;
    logic [31:0] wPlus1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } expItem_t;

    expItem_t sb[$];

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0020)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .jmp_i         (jmp_i),
        .jmp_target_i  (jmp_target_i),
        .exc_i         (exc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_pc_plus1_o (if_pc_plus1_o)
    );

    pc_fetch_unit #(
        .RESET_PC   (32'hFFFF_FFFF),
        .EXC_VECTOR (32'h0000_0020)
    ) u_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (wZero),
        .br_taken_i    (wZero),
        .br_target_i   (wZeroWord),
        .jmp_i         (wZero),
        .jmp_target_i  (wZeroWord),
        .exc_i         (wZero),
        .imem_req_o    (wReq),
        .imem_addr_o   (wAddr),
        .imem_ack_i    (wAck),
        .imem_rdata_i  (wRdata),
        .if_valid_o    (wValid),
        .if_instr_o    (wInstr),
        .if_pc_o       (wPc),
        .if_pc_plus1_o (wPlus1)
    );

    // Instruction memory contents: a recognisable word derived from the address.
    function automatic logic [31:0] instrFor(input logic [31:0] addr);
        return 32'hA500_0000 ^ (addr & 32'h00FF_FFFF) ^ {addr[7:0], 24'h0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Verify the request is up at the expected address, return the word, and
    // record it in the scoreboard when it is meant to reach IF/ID.
    task automatic ackAt(input logic [31:0] addr, input logic keep);
        expItem_t item;
        checkBit("req_before_ack", imem_req_o, 1'b1);
        checkOutput("addr_before_ack", imem_addr_o, addr);
        imem_ack_i   = 1'b1;
        imem_rdata_i = instrFor(addr);
        if (keep) begin
            item.pc    = addr;
            item.instr = instrFor(addr);
            sb.push_back(item);
        end
    endtask

    // Score any consumption happening this cycle, advance one clock, drop pulses.
    task automatic applyStimulus();
        expItem_t item;
        if (if_valid_o && !stall_i) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("[TB] FAIL sb_underflow: observed=consume pc %h expected=no valid output", if_pc_o);
            end
            if (sb.size() != 0) begin
                item = sb.pop_front();
                checkOutput("if_pc", if_pc_o, item.pc);
                checkOutput("if_instr", if_instr_o, item.instr);
                checkOutput("if_pc_plus1", if_pc_plus1_o, item.pc + 32'd1);
            end
        end
        @(posedge clk);
        #1;
        imem_ack_i = 1'b0;
        br_taken_i = 1'b0;
        jmp_i      = 1'b0;
        exc_i      = 1'b0;
        wAck       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        stall_i      = 1'b0;
        br_taken_i   = 1'b0;
        br_target_i  = '0;
        jmp_i        = 1'b0;
        jmp_target_i = '0;
        exc_i        = 1'b0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
        wAck         = 1'b0;
        wRdata       = '0;
        wZero        = 1'b0;
        wZeroWord    = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkBit("rst_req", imem_req_o, 1'b0);
        checkOutput("rst_addr", imem_addr_o, 32'h0);
        checkBit("rst_valid", if_valid_o, 1'b0);
        checkOutput("rst_instr", if_instr_o, 32'h0);
        checkOutput("rst_if_pc", if_pc_o, 32'h0);
        checkOutput("rst_pc_plus1", if_pc_plus1_o, 32'h0);

        // Leave reset with a stale ack during BOOT.
        rst_n        = 1'b1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        applyStimulus();
        checkBit("boot_to_req", imem_req_o, 1'b1);
        checkOutput("boot_addr", imem_addr_o, 32'h0);
        checkBit("boot_ack_ignored", if_valid_o, 1'b0);

        // Test 1: reset asserted in the middle of a request.
        rst_n = 1'b0;
        #1;
        checkBit("async_reset_req", imem_req_o, 1'b0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        checkBit("t1_boot_req", imem_req_o, 1'b0);
        applyStimulus();
        checkBit("t1_req", imem_req_o, 1'b1);
        checkOutput("t1_addr", imem_addr_o, 32'h0);
        checkBit("t1_stale_ack", if_valid_o, 1'b0);

        // Test 2: back-to-back single-cycle acks.
        for (int i = 0; i < 5; i++) begin
            ackAt(32'(i), 1'b1);
            stall_i = 1'b0;
            applyStimulus();
            checkBit("t2_valid", if_valid_o, 1'b1);
        end

        // Test 3: ack for address 5 under a three-cycle stall.
        ackAt(32'h5, 1'b1);
        stall_i = 1'b1;
        applyStimulus();
        repeat (2) begin
            checkBit("t3_hold_req", imem_req_o, 1'b0);
            checkBit("t3_hold_valid", if_valid_o, 1'b1);
            checkOutput("t3_instr_stable", if_instr_o, instrFor(32'h4));
            applyStimulus();
        end
        stall_i = 1'b0;
        checkBit("t3_last_hold_req", imem_req_o, 1'b0);
        applyStimulus();
        checkBit("t3_resume_req", imem_req_o, 1'b1);
        checkOutput("t3_resume_addr", imem_addr_o, 32'h6);
        checkOutput("t3_parked_pc", if_pc_o, 32'h5);

        // Test 4: taken branch while address 7 is outstanding.
        ackAt(32'h6, 1'b1);
        applyStimulus();
        checkOutput("t4_addr7", imem_addr_o, 32'h7);
        br_taken_i  = 1'b1;
        br_target_i = 32'h100;
        applyStimulus();
        checkBit("t4_flushed", if_valid_o, 1'b0);
        checkOutput("t4_addr_held", imem_addr_o, 32'h7);
        applyStimulus();
        checkOutput("t4_addr_still_held", imem_addr_o, 32'h7);
        imem_ack_i   = 1'b1;
        imem_rdata_i = instrFor(32'h7);
        applyStimulus();
        checkBit("t4_dropped", if_valid_o, 1'b0);
        checkBit("t4_req", imem_req_o, 1'b1);
        checkOutput("t4_branch_addr", imem_addr_o, 32'h100);

        // Test 5: simultaneous redirects while stalled, then a jump with ack.
        ackAt(32'h100, 1'b0);
        applyStimulus();
        checkBit("t5_captured", if_valid_o, 1'b1);
        stall_i      = 1'b1;
        exc_i        = 1'b1;
        jmp_i        = 1'b1;
        jmp_target_i = 32'h40;
        br_taken_i   = 1'b1;
        br_target_i  = 32'h80;
        applyStimulus();
        checkBit("t5_flush_under_stall", if_valid_o, 1'b0);
        checkOutput("t5_addr_held", imem_addr_o, 32'h101);
        stall_i      = 1'b0;
        imem_ack_i   = 1'b1;
        imem_rdata_i = instrFor(32'h101);
        applyStimulus();
        checkOutput("t5_exc_vector", imem_addr_o, 32'h20);
        ackAt(32'h20, 1'b1);
        applyStimulus();
        ackAt(32'h21, 1'b0);
        jmp_i        = 1'b1;
        jmp_target_i = 32'h40;
        applyStimulus();
        checkBit("t5_jmp_flush", if_valid_o, 1'b0);
        checkOutput("t5_jmp_addr", imem_addr_o, 32'h40);
        ackAt(32'h40, 1'b1);
        applyStimulus();
        applyStimulus();
        checkOutput("sb_drained", 32'(sb.size()), 32'h0);

        // Test 6: PC wrap on the instance booting at the top of memory.
        checkBit("t6_req", wReq, 1'b1);
        checkOutput("t6_addr", wAddr, 32'hFFFF_FFFF);
        wAck   = 1'b1;
        wRdata = instrFor(32'hFFFF_FFFF);
        applyStimulus();
        checkBit("t6_valid", wValid, 1'b1);
        checkOutput("t6_if_pc", wPc, 32'hFFFF_FFFF);
        checkOutput("t6_instr", wInstr, instrFor(32'hFFFF_FFFF));
        checkOutput("t6_plus1_wrap", wPlus1, 32'h0);
        checkOutput("t6_next_addr", wAddr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
